// File: rtl/bitwise_pkg.sv
// Shared definitions for the chunk-serial bitwise unit: operation and state
// encodings plus the flag-selection helper used when the last chunk retires.
package bitwise_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Slice counter width: enough to index every chunk, never narrower than 1.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

    // Flag output: logical ops report 0 or the captured carry, the upper two
    // ops report the zero / parity status of operand A.
    function automatic logic cout_sel(input logic [1:0] op, input logic cin,
                                      input logic a_zero, input logic a_parity);
        if (op[1]) return op[0] ? a_parity : a_zero;
        else       return op[0] ? cin      : 1'b0;
    endfunction

endpackage

// File: rtl/bitwise_slice.sv
// Combinational per-chunk logic: applies the selected bitwise operation to one
// SLICE-bit chunk and reports whether the A chunk is zero and its parity.
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] q,
    output logic             chunk_zero,
    output logic             chunk_parity
);

    // Bitwise operation on the current chunk.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        q = '0;
        unique case (op_e'(op))
            OP_AND:  q = a & b;
            OP_OR:   q = a | b;
            OP_XOR:  q = a ^ b;
            OP_NAND: q = ~(a & b);
            default: q = '0;
        endcase
    end

    assign chunk_zero   = (a == '0);
    assign chunk_parity = ^a;

endmodule

// File: rtl/bitwise_serial.sv
// Chunk-serial bitwise unit: captures an operand set in IDLE, processes one
// SLICE-bit chunk per cycle (LSB chunk first) in RUN, and holds the result in
// DONE until the consumer accepts it. Zero and parity of A are accumulated
// chunk by chunk alongside the result.
module bitwise_serial
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             cout
);

    localparam int CHUNKS = WIDTH / SLICE;
    localparam int CNT_W  = cnt_width(CHUNKS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q, zero_d;
    logic             par_q, par_d;

    logic [SLICE-1:0] chunk_q;
    logic             chunk_zero;
    logic             chunk_parity;
    logic [WIDTH-1:0] q_shifted;

    // The lowest chunk of the shifting operand registers is always the one in flight.
    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .a            (a_q[SLICE-1:0]),
        .b            (b_q[SLICE-1:0]),
        .op           (op_q),
        .q            (chunk_q),
        .chunk_zero   (chunk_zero),
        .chunk_parity (chunk_parity)
    );

    // Result assembly: each new chunk enters at the MSB side and older chunks
    // move down, so after the last chunk chunk 0 sits in the LSBs.
    if (CHUNKS == 1) begin : g_single
        assign q_shifted = chunk_q;
    end else begin : g_multi
        assign q_shifted = {chunk_q, q_q[WIDTH-1:SLICE]};
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        q_d     = q_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        par_d   = par_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cin_d   = cin;
                    q_d     = '0;
                    cout_d  = 1'b0;
                    cnt_d   = '0;
                    zero_d  = 1'b1;
                    par_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = a_q >> SLICE;
                b_d    = b_q >> SLICE;
                q_d    = q_shifted;
                zero_d = zero_q & chunk_zero;
                par_d  = par_q ^ chunk_parity;
                if (cnt_q == LAST_CNT) begin
                    // Flag is resolved with the last chunk folded in.
                    cout_d  = cout_sel(op_q, cin_q, zero_d, par_d);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so an aborted operation never leaves a partial q/cout visible.
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            cin_q   <= 1'b0;
            q_q     <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            zero_q  <= 1'b1;
            par_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            q_q     <= q_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            par_q   <= par_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = q_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bitwise_serial.sv
// Self-checking bench for bitwise_serial: a 16/4 instance driven from a vector
// table through a result scoreboard, plus an 8/8 instance for the single-chunk build.
module tb_bitwise_serial;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // 16-bit, 4-bit-slice instance
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, q;
    logic [1:0]  op;

    bitwise_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .q(q), .cout(cout)
    );

    // 8-bit, single-slice instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
    logic [7:0] a8, b8, q8;
    logic [1:0] op8;

    bitwise_serial #(.WIDTH(8), .SLICE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .cin(cin8), .out_valid(out_valid8),
        .out_ready(out_ready8), .q(q8), .cout(cout8)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [15:0] exp_q;
        logic        exp_cout;
        int          stall;
    } vec_t;

    typedef struct packed {
        logic [15:0] q;
        logic        cout;
    } res_t;

    vec_t vecs[12];
    res_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One full transaction on the 16/4 instance; stall = cycles out_ready is held low in DONE.
    task automatic run_vec(input vec_t v);
        int   lat;
        bit   seen;
        res_t exp;
        logic [15:0] hold_q;
        logic        hold_c;
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; cin = v.cin;
        in_valid  = 1'b1;
        out_ready = (v.stall == 0);   // held high through RUN: must be ignored there
        check("in_ready before accept", in_ready, 1);
        @(posedge clk);
        sb.push_back('{q: v.exp_q, cout: v.exp_cout});
        #1;
        in_valid = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        op  = 2'($urandom_range(0, 3));
        cin = 1'($urandom_range(0, 1));
        check("in_ready in RUN", in_ready, 0);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("latency", lat, 4);
        if (!seen) begin
            void'(sb.pop_front());
            return;
        end
        hold_q = q;
        hold_c = cout;
        for (int s = 0; s < v.stall; s++) begin
            @(posedge clk);
            #1;
            check("stall q stable", q, hold_q);
            check("stall cout stable", cout, hold_c);
            check("stall in_ready low", in_ready, 0);
            check("stall out_valid held", out_valid, 1);
        end
        check("in_ready low in DONE", in_ready, 0);
        exp = sb.pop_front();
        check("result q", q, exp.q);
        check("result cout", cout, exp.cout);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid after handshake", out_valid, 0);
        check("in_ready after handshake", in_ready, 1);
    endtask

    // One transaction on the 8/8 instance; result must appear one cycle after accept.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop,
                        input logic vcin, input logic [7:0] eq, input logic ec);
        @(negedge clk);
        a8 = va; b8 = vb; op8 = vop; cin8 = vcin;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8 = ~va; b8 = 8'($urandom); op8 = ~vop; cin8 = ~vcin;
        check("w8 running", out_valid8, 0);
        @(posedge clk);
        #1;
        check("w8 latency 1", out_valid8, 1);
        check("w8 q", q8, eq);
        check("w8 cout", cout8, ec);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        check("w8 back to idle", in_ready8, 1);
    endtask

    initial begin
        bit any_valid;

        //              a        b        op     cin   exp_q    cout  stall
        vecs[0]  = '{16'hF0F0, 16'hFF00, 2'b00, 1'b0, 16'hF000, 1'b0, 2};
        vecs[1]  = '{16'h0000, 16'h1234, 2'b10, 1'b0, 16'h1234, 1'b1, 0};
        vecs[2]  = '{16'h0001, 16'h1234, 2'b10, 1'b0, 16'h1235, 1'b0, 0};
        vecs[3]  = '{16'h0007, 16'hFFFF, 2'b11, 1'b0, 16'hFFF8, 1'b1, 0};
        vecs[4]  = '{16'h0003, 16'hFFFF, 2'b11, 1'b0, 16'hFFFC, 1'b0, 0};
        vecs[5]  = '{16'h00FF, 16'h0F00, 2'b01, 1'b1, 16'h0FFF, 1'b1, 5};
        vecs[6]  = '{16'h1234, 16'h4321, 2'b01, 1'b0, 16'h5335, 1'b0, 0};
        vecs[7]  = '{16'hFFFF, 16'hA5A5, 2'b00, 1'b1, 16'hA5A5, 1'b0, 0};
        vecs[8]  = '{16'h8000, 16'h0000, 2'b10, 1'b0, 16'h8000, 1'b0, 0};
        vecs[9]  = '{16'h8001, 16'h0F0F, 2'b11, 1'b1, 16'hFFFE, 1'b0, 0};
        vecs[10] = '{16'h8000, 16'hFFFF, 2'b11, 1'b0, 16'h7FFF, 1'b1, 1};
        vecs[11] = '{16'h0000, 16'hFFFF, 2'b10, 1'b1, 16'hFFFF, 1'b1, 0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0; cin8 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset q", q, 0);
        check("reset cout", cout, 0);
        check("reset out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);
        check("w8 in_ready after reset", in_ready8, 1);

        // out_ready while idle must not disturb anything
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle out_ready ignored", out_valid, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of RUN discards the operation
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; op = 2'b01; cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-run reset q", q, 0);
        check("mid-run reset cout", cout, 0);
        check("mid-run reset out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready after mid-run reset", in_ready, 1);
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) any_valid = 1'b1;
        end
        check("no result after aborted op", any_valid, 0);

        // Operation after the abort still works
        run_vec(vecs[6]);

        // Single-chunk build
        run8(8'h3C, 8'h0F, 2'b10, 1'b0, 8'h33, 1'b0);
        run8(8'h00, 8'hA5, 2'b10, 1'b0, 8'hA5, 1'b1);
        run8(8'h07, 8'hFF, 2'b11, 1'b0, 8'hF8, 1'b1);
        run8(8'h81, 8'h40, 2'b01, 1'b1, 8'hC1, 1'b1);

        check("scoreboard drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
